// File: rtl/cam_capture.sv
// OV7670 pixel capture: assembles RGB444 byte pairs into 12-bit pixels, optionally
// decimates 2:1, and emits a linear write stream into the camera frame buffer.
module cam_capture #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DECIM = 2,
   parameter int AW    = 17
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_continuous,
   input  logic          i_vsync,
   input  logic          i_href,
   input  logic [7:0]    i_data,
   output logic          o_wr_en,
   output logic [AW-1:0] o_wr_addr,
   output logic [11:0]   o_wr_data,
   output logic          o_busy,
   output logic          o_frame_done,
   output logic [7:0]    o_frame_cnt,
   output logic          o_line_err
);

   localparam int NPIX = (IMG_W / DECIM) * (IMG_H / DECIM);
   localparam int XW   = $clog2(IMG_W + 2);
   localparam int YW   = $clog2(IMG_H + 1);
   localparam int CW   = AW + 1;
   localparam bit DEC2 = (DECIM == 2);

   localparam logic [XW-1:0] X_END  = XW'(IMG_W);
   localparam logic [XW-1:0] X_MAX  = XW'(IMG_W + 1);
   localparam logic [YW-1:0] Y_END  = YW'(IMG_H);
   localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_SOF = 2'd1;
   localparam logic [1:0] S_CAPTURE  = 2'd2;

   logic [1:0]    state;
   logic          vs_p0, hr_p0, vs_p1, hr_p1;
   logic [7:0]    d_p0;
   logic [3:0]    red;
   logic          phase;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [CW-1:0] wr_cnt;

   logic vs_fall, vs_rise, hr_fall, byte_vld, pix_keep;

   assign vs_fall  = vs_p1 & ~vs_p0;
   assign vs_rise  = ~vs_p1 & vs_p0;
   assign hr_fall  = hr_p1 & ~hr_p0;
   assign byte_vld = (state == S_CAPTURE) && hr_p0;
   // x/y still hold the index of the pixel being completed this cycle
   assign pix_keep = (x < X_END) && (y < Y_END) && (!DEC2 || (!x[0] && !y[0]))
                     && (wr_cnt < NPIX_C);
   assign o_busy   = (state != S_IDLE);

   // p0: camera pins registered; p1: one-cycle delayed copy for edge detection
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vs_p0 <= 1'b0;
         hr_p0 <= 1'b0;
         d_p0  <= 8'd0;
         vs_p1 <= 1'b0;
         hr_p1 <= 1'b0;
      end else begin
         vs_p0 <= i_vsync;
         hr_p0 <= i_href;
         d_p0  <= i_data;
         vs_p1 <= vs_p0;
         hr_p1 <= hr_p0;
      end
   end

   // p2: frame state, byte assembly and registered write port
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         red          <= 4'd0;
         phase        <= 1'b0;
         x            <= '0;
         y            <= '0;
         wr_cnt       <= '0;
         o_wr_en      <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= 12'd0;
         o_frame_done <= 1'b0;
         o_frame_cnt  <= 8'd0;
         o_line_err   <= 1'b0;
      end else begin
         o_wr_en      <= 1'b0;
         o_frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state      <= S_WAIT_SOF;
                  o_line_err <= 1'b0;
               end
            end
            S_WAIT_SOF: begin
               if (vs_fall) begin
                  state     <= S_CAPTURE;
                  x         <= '0;
                  y         <= '0;
                  wr_cnt    <= '0;
                  o_wr_addr <= '0;
                  phase     <= 1'b0;
               end
            end
            S_CAPTURE: begin
               if (byte_vld) begin
                  phase <= ~phase;
                  if (!phase) begin
                     red <= d_p0[3:0];
                  end else begin
                     if (x != X_MAX) x <= x + 1'b1;
                     if (pix_keep) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= wr_cnt[AW-1:0];
                        o_wr_data <= {red, d_p0};
                        wr_cnt    <= wr_cnt + 1'b1;
                     end
                  end
               end
               if (hr_fall) begin
                  if ((x != X_END) || phase) o_line_err <= 1'b1;
                  x     <= '0;
                  phase <= 1'b0;
                  if (y != Y_END) y <= y + 1'b1;
               end
               // a pixel completed in this same cycle is still written above
               if (vs_rise) begin
                  o_frame_done <= 1'b1;
                  o_frame_cnt  <= o_frame_cnt + 8'd1;
                  state        <= i_continuous ? S_WAIT_SOF : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Pixel-capture stage between the OV7670 camera pins (pclk, vsync, href, 8-bit data) and the camera frame buffer inside the SoC core.
- Assembles RGB444 byte pairs into 12-bit pixels and optionally decimates 2:1 in both axes.
- Emits a linear write stream (enable, address, data) to the frame-buffer RAM.
- Runs entirely in the camera pixel-clock domain.
- Frames are armed by a start pulse, either single-shot or continuous.

Parameters:
- IMG_W, 640, active pixels per camera line (each pixel is 2 bytes).
- IMG_H, 480, active lines per camera frame.
- DECIM, 2, decimation factor; legal values 1 or 2.
- AW, 17, write-address width; 2^AW >= (IMG_W/DECIM)*(IMG_H/DECIM), which is 76800 at defaults.

Ports:
- i_clk  in  1  camera pixel clock (pclk); all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle arm request.
- i_continuous  in  1  level; 1 = re-arm automatically after each frame.
- i_vsync  in  1  camera vsync; high during vertical blanking.
- i_href  in  1  camera href; high during active bytes of a line.
- i_data  in  8  camera pixel byte.
- o_wr_en  out  1  frame-buffer write strobe.
- o_wr_addr  out  AW  frame-buffer write address.
- o_wr_data  out  12  pixel as {R[3:0],G[3:0],B[3:0]}.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_done  out  1  one-cycle pulse at end of a captured frame.
- o_frame_cnt  out  8  completed-frame counter; wraps 255->0.
- o_line_err  out  1  sticky; a line ended with pixel count != IMG_W.

Behaviour:
- **Reset:** i_rst asserted at any time, including mid-frame, immediately forces:
  - state = IDLE;
  - all outputs 0;
  - all counters and input registers 0;
  - no write is issued after the assertion.
- **Input registration:** i_vsync, i_href and i_data are registered once (vs_r, hr_r, d_r). All decisions use the registered values.
  - Edge detect: vs_fall = vs_r & ~vsync_in_reg_now; equivalent one-cycle delayed compare.
- **State machine:**
  - IDLE: i_start=1 -> WAIT_SOF. Clears o_line_err.
  - WAIT_SOF: vs_r falling edge -> CAPTURE. Clears x, y, o_wr_addr and byte phase.
  - CAPTURE: vs_r rising edge -> end of frame.
    - o_frame_done=1 for exactly one cycle.
    - o_frame_cnt increments.
    - Next state is WAIT_SOF if i_continuous=1 at that cycle, else IDLE.
  - i_start is ignored outside IDLE.
- **Byte assembly (CAPTURE, hr_r=1):** phase toggles on every byte.
  - phase 0: latch red = d_r[3:0].
  - phase 1: pixel = {red, d_r[7:0]}; x increments.
- **Write emission:** a pixel is written when all of the following hold:
  - x < IMG_W and y < IMG_H;
  - DECIM=1, or x[0]=0 and y[0]=0.
  - Write timing: registered; o_wr_en=1 for one cycle, the cycle after the phase-1 byte sits in d_r. That is 2 rising edges after the second byte is present on i_data.
  - o_wr_addr carries the current address; the address increments after each write.
  - Writes never exceed (IMG_W/DECIM)*(IMG_H/DECIM)-1. Surplus pixels or lines produce no write.
- **Line end (hr_r falling in CAPTURE):**
  - If x != IMG_W or phase=1: set o_line_err.
  - Then y++, x=0, phase=0.
  - y saturates at IMG_H.
- **href while vsync high:** ignored (no bytes counted).
- **Simultaneous events:** vs_r rising in the same cycle as the last phase-1 byte: the pixel write is still emitted in the following cycle together with the o_frame_done pulse.
- **o_wr_en:** 0 in IDLE and WAIT_SOF.

Test Plan:
- **Basic 2:1 frame** (IMG_W=8, IMG_H=4, DECIM=2): i_start, then vsync high->low, then 4 lines of 16 bytes with byte pairs (0x0A,0xBC).
  - Expect exactly 8 writes, addr 0..7, data 0xABC.
  - One o_frame_done on vsync rise; o_frame_cnt=1; o_busy falls.
- **Full resolution** (DECIM=1, same frame): expect 32 writes, addr 0..31, and pixel order matching the byte stream.
- **Short line:** line 1 carries 14 bytes.
  - o_line_err=1 and stays set until the next i_start from IDLE.
  - No write address exceeds 7.
- **Continuous mode:** i_continuous=1 across 3 frames.
  - o_frame_cnt=3; addresses restart at 0 each frame.
  - i_start pulses during CAPTURE have no effect.
- **Reset mid-frame:** assert i_rst after the 5th write.
  - Same cycle: all outputs 0, no further writes.
  - After deassert, the block stays IDLE despite continuing href/vsync activity.
- **Arm timing:** i_start issued mid-frame while vsync is low.
  - No writes until the next vsync falling edge; the first write then goes to addr 0.
